// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path: digit slot map, colon slots
// and the RTC core's 7-segment encodings (bit0 = a ... bit6 = g, 1 = lit).
package clock_disp_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    typedef logic [2:0] slot_t;

    localparam slot_t SLOT_SL   = 3'd0;
    localparam slot_t SLOT_SM   = 3'd1;
    localparam slot_t SLOT_ML   = 3'd2;
    localparam slot_t SLOT_MM   = 3'd3;
    localparam slot_t SLOT_HL   = 3'd4;
    localparam slot_t SLOT_HM   = 3'd5;
    localparam slot_t LAST_SLOT = SLOT_HM;

    localparam slot_t COLON_SLOT_A = 3'd2;
    localparam slot_t COLON_SLOT_B = 3'd4;

    localparam logic [6:0] SEG_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_ONE   = 7'h06;
    localparam logic [6:0] SEG_TWO   = 7'h5B;
    localparam logic [6:0] SEG_THREE = 7'h4F;
    localparam logic [6:0] SEG_FOUR  = 7'h66;
    localparam logic [6:0] SEG_FIVE  = 7'h6D;
    localparam logic [6:0] SEG_SIX   = 7'h7D;
    localparam logic [6:0] SEG_SEVEN = 7'h07;
    localparam logic [6:0] SEG_EIGHT = 7'h7F;
    localparam logic [6:0] SEG_NINE  = 7'h6F;

    function automatic logic [NUM_DIGITS-1:0] slot_onehot(input slot_t slot);
        logic [NUM_DIGITS-1:0] oh;
        oh       = '0;
        oh[slot] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-slot sequencer: prescale counter pc, slot index s, and the
// frame snapshot strobe raised while pc and s are both zero.
module scan_timer
    import clock_disp_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PC_W     = $clog2(PRESCALE)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc,
    output slot_t           s,
    output logic            snap
);

    logic [PC_W-1:0] pc_q;
    slot_t           s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
            s_q  <= SLOT_SL;
        end else if (pc_q == PC_W'(PRESCALE - 1)) begin
            pc_q <= '0;
            s_q  <= (s_q == LAST_SLOT) ? SLOT_SL : s_q + 3'd1;
        end else begin
            pc_q <= pc_q + PC_W'(1);
        end
    end

    assign pc   = pc_q;
    assign s    = s_q;
    assign snap = (pc_q == '0) && (s_q == SLOT_SL);

endmodule

// File: rtl/clock_display_scan.sv
// Multiplexed 6-digit 7-segment driver: per-frame input snapshot, guard
// interval at the start of each slot, hours-tens blanking and colon dp.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned GUARD    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            sl,
    input  logic [6:0]            sm,
    input  logic [6:0]            ml,
    input  logic [6:0]            mm,
    input  logic [6:0]            hl,
    input  logic [6:0]            hm,
    input  logic                  blank_hm,
    input  logic                  colon_on,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam int unsigned PC_W = $clog2(PRESCALE);

    logic [PC_W-1:0] pc;
    slot_t           s;
    logic            snap;

    scan_timer #(
        .PRESCALE(PRESCALE),
        .PC_W    (PC_W)
    ) u_scan_timer (
        .clk (clk),
        .rst (rst),
        .pc  (pc),
        .s   (s),
        .snap(snap)
    );

    // Inputs are only sampled here, so a frame never mixes two time values.
    logic [6:0] fb_q [NUM_DIGITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                fb_q[i] <= '0;
            end
        end else if (snap) begin
            fb_q[SLOT_SL] <= sl;
            fb_q[SLOT_SM] <= sm;
            fb_q[SLOT_ML] <= ml;
            fb_q[SLOT_MM] <= mm;
            fb_q[SLOT_HL] <= hl;
            fb_q[SLOT_HM] <= hm;
        end
    end

    logic                  blank;
    logic                  active;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    always_comb begin
        blank  = (s == SLOT_HM) && blank_hm && (fb_q[SLOT_HM] == SEG_ZERO);
        active = (32'(pc) >= GUARD) && !blank;
        an_d   = '0;
        seg_d  = '0;
        dp_d   = 1'b0;
        if (active) begin
            an_d  = slot_onehot(s);
            seg_d = fb_q[s];
            dp_d  = colon_on && ((s == COLON_SLOT_A) || (s == COLON_SLOT_B));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an          <= '0;
            seg         <= '0;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= snap;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan: fixed vector tables, hand
// sequences for tearing/blanking/reset, and a cycle-position reference model.
module tb_clock_display_scan;

    localparam int P     = 4;
    localparam int G     = 1;
    localparam int FRAME = 6 * P;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] sl, sm, ml, mm, hl, hm;
    logic       blank_hm, colon_on;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_start;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    clock_display_scan #(
        .PRESCALE(P),
        .GUARD   (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sl         (sl),
        .sm         (sm),
        .ml         (ml),
        .mm         (mm),
        .hl         (hl),
        .hm         (hm),
        .blank_hm   (blank_hm),
        .colon_on   (colon_on),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    // Reference model: output after edge e depends only on e's position in
    // the frame and on the inputs captured at the frame's first edge.
    int         m_ecnt;
    int         last_pos;
    int         m_pos, m_k, m_ph;
    logic [6:0] m_fb [6];
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ecnt   = 0;
            last_pos = -1;
            for (int i = 0; i < 6; i++) m_fb[i] = 7'h00;
            e_an  = 6'd0;
            e_seg = 7'h00;
            e_dp  = 1'b0;
            e_fs  = 1'b0;
        end else begin
            m_pos = m_ecnt % FRAME;
            m_k   = m_pos / P;
            m_ph  = m_pos % P;
            if (m_pos == 0) begin
                m_fb[0] = sl; m_fb[1] = sm; m_fb[2] = ml;
                m_fb[3] = mm; m_fb[4] = hl; m_fb[5] = hm;
            end
            e_fs  = (m_pos == 0);
            e_an  = 6'd0;
            e_seg = 7'h00;
            e_dp  = 1'b0;
            if (m_ph >= G && !(m_k == 5 && blank_hm && m_fb[5] == 7'h3F)) begin
                e_an  = 6'd1 << m_k;
                e_seg = m_fb[m_k];
                e_dp  = colon_on && (m_k == 2 || m_k == 4);
            end
            last_pos = m_pos;
            m_ecnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_start !== e_fs) begin
                bad++;
                $display("FAIL model t=%0t an=%b/%b seg=%h/%h dp=%b/%b fs=%b/%b (got/exp)",
                         $time, an, e_an, seg, e_seg, dp, e_dp, frame_start, e_fs);
            end
            total++;
            if ($countones(an) > 1) begin
                bad++;
                $display("FAIL onehot t=%0t an=%b required at most one bit", $time, an);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (last_pos != target && n < 4 * FRAME);
        check("wait_pos", 32'(last_pos), 32'(target));
    endtask

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
    } scan_t;

    typedef struct {
        logic [6:0] hm;
        logic       blank;
        logic       colon;
        int         an5_cycles;
        int         dp_cycles;
    } blank_vec_t;

    scan_t      scan_tab [6];
    blank_vec_t blank_tab[4];
    logic [6:0] digits   [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, ph, c5, cdp;

        scan_tab[0] = '{6'b000001, 7'h06};
        scan_tab[1] = '{6'b000010, 7'h5B};
        scan_tab[2] = '{6'b000100, 7'h4F};
        scan_tab[3] = '{6'b001000, 7'h66};
        scan_tab[4] = '{6'b010000, 7'h6D};
        scan_tab[5] = '{6'b100000, 7'h7D};

        blank_tab[0] = '{7'h3F, 1'b1, 1'b0, 0, 0};
        blank_tab[1] = '{7'h3F, 1'b0, 1'b1, P - G, 2 * (P - G)};
        blank_tab[2] = '{7'h06, 1'b1, 1'b1, P - G, 2 * (P - G)};
        blank_tab[3] = '{7'h06, 1'b0, 1'b0, P - G, 0};

        digits = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        rst = 1'b0;
        sl = 7'h06; sm = 7'h5B; ml = 7'h4F; mm = 7'h66; hl = 7'h6D; hm = 7'h7D;
        blank_hm = 1'b0;
        colon_on = 1'b0;
        chk_en   = 1'b1;

        repeat (5) begin
            @(negedge clk);
            check("reset_outputs", 32'({an, seg, dp, frame_start}), 32'd0);
        end
        #1 rst = 1'b1;

        // Scan order and frame_start over three frames.
        for (int e = 0; e < 3 * FRAME; e++) begin
            @(negedge clk);
            k  = (e % FRAME) / P;
            ph = e % P;
            check("scan_frame_start", 32'(frame_start), 32'((e % FRAME) == 0));
            if (ph < G) begin
                check("scan_guard", 32'({an, seg}), 32'd0);
            end else begin
                check("scan_an", 32'(an), 32'(scan_tab[k].an));
                check("scan_seg", 32'(seg), 32'(scan_tab[k].seg));
            end
        end

        // No tearing: change mid-frame, old values persist until next frame.
        wait_pos(12);
        #1 sl = 7'h3F; hm = 7'h3F;
        wait_pos(21);
        check("tear_an5_old", 32'(an), 32'(6'b100000));
        check("tear_seg5_old", 32'(seg), 32'(7'h7D));
        wait_pos(1);
        check("tear_an0_new", 32'(an), 32'(6'b000001));
        check("tear_seg0_new", 32'(seg), 32'(7'h3F));
        wait_pos(21);
        check("tear_seg5_new", 32'(seg), 32'(7'h3F));

        // Blanking and colon, one full frame per vector.
        for (int i = 0; i < 4; i++) begin
            wait_pos(FRAME - 1);
            #1;
            hm       = blank_tab[i].hm;
            blank_hm = blank_tab[i].blank;
            colon_on = blank_tab[i].colon;
            c5  = 0;
            cdp = 0;
            for (int j = 0; j < FRAME; j++) begin
                @(negedge clk);
                if (an[5]) begin
                    c5++;
                    check("blank_seg5", 32'(seg), 32'(blank_tab[i].hm));
                end
                if (dp) begin
                    cdp++;
                    check("colon_dp_slot", 32'(an & 6'b010100) != 0, 32'd1);
                end
            end
            check("blank_an5_cycles", 32'(c5), 32'(blank_tab[i].an5_cycles));
            check("colon_dp_cycles", 32'(cdp), 32'(blank_tab[i].dp_cycles));
        end

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 5) == 0) sl = digits[$urandom_range(0, 9)];
            if ($urandom_range(0, 5) == 0) sm = digits[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 0) ml = digits[$urandom_range(0, 9)];
            if ($urandom_range(0, 5) == 0) mm = digits[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 0) hl = digits[$urandom_range(0, 9)];
            if ($urandom_range(0, 5) == 0) hm = digits[$urandom_range(0, 2)];
            if ($urandom_range(0, 15) == 0) blank_hm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) colon_on = 1'($urandom_range(0, 1));
        end

        // Reset during slot 4: immediate clear, then a fresh restart.
        wait_pos(17);
        #1;
        sl = 7'h07; sm = 7'h7F; ml = 7'h6F; mm = 7'h5B; hl = 7'h4F; hm = 7'h06;
        colon_on = 1'b1;
        rst = 1'b0;
        #1;
        check("reset_async", 32'({an, seg, dp, frame_start}), 32'd0);
        @(negedge clk);
        check("reset_hold", 32'({an, seg, dp, frame_start}), 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("restart_fs", 32'(frame_start), 32'd1);
        check("restart_guard", 32'(an), 32'd0);
        @(negedge clk);
        check("restart_an", 32'(an), 32'(6'b000001));
        check("restart_seg", 32'(seg), 32'(7'h07));
        repeat (2 * FRAME) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
